// File: rtl/cam_access_arbiter_if.sv
// Request/result/CAM signal bundle for cam_access_arbiter.
// The slave modport is the arbiter's view; master is the requester/CAM side.
interface cam_access_arbiter_if #(
    parameter int unsigned C_TCAM_ADDR_WIDTH       = 5,
    parameter int unsigned C_TCAM_DATA_WIDTH       = 32,
    parameter int unsigned C_TCAM_MATCH_ADDR_WIDTH = 5
);
    logic                               lkp_valid;
    logic [C_TCAM_DATA_WIDTH-1:0]       lkp_key;
    logic                               lkp_ready;
    logic                               res_valid;
    logic                               res_match;
    logic [C_TCAM_MATCH_ADDR_WIDTH-1:0] res_addr;
    logic                               wr_valid;
    logic [C_TCAM_ADDR_WIDTH-1:0]       wr_addr;
    logic [C_TCAM_DATA_WIDTH-1:0]       wr_data;
    logic                               wr_ready;
    logic                               wr_done;
    logic                               cam_we;
    logic [C_TCAM_ADDR_WIDTH-1:0]       cam_addr_wr;
    logic [C_TCAM_DATA_WIDTH-1:0]       cam_din;
    logic                               cam_busy;
    logic [C_TCAM_DATA_WIDTH-1:0]       cam_cmp_din;
    logic                               cam_match;
    logic [C_TCAM_MATCH_ADDR_WIDTH-1:0] cam_match_addr;

    modport slave (
        input  lkp_valid, lkp_key, wr_valid, wr_addr, wr_data,
        input  cam_busy, cam_match, cam_match_addr,
        output lkp_ready, res_valid, res_match, res_addr, wr_ready, wr_done,
        output cam_we, cam_addr_wr, cam_din, cam_cmp_din
    );

    modport master (
        output lkp_valid, lkp_key, wr_valid, wr_addr, wr_data,
        output cam_busy, cam_match, cam_match_addr,
        input  lkp_ready, res_valid, res_match, res_addr, wr_ready, wr_done,
        input  cam_we, cam_addr_wr, cam_din, cam_cmp_din
    );
endinterface

// File: rtl/cam_access_arbiter.sv
// Shares one CAM between a pipelined lookup stream and serialised, starvation-bounded writes.
// Define CAM_ARB_STATS_EN to add the stat_lookups/stat_hits/stat_writes counters.
module cam_access_arbiter #(
    parameter int unsigned C_TCAM_ADDR_WIDTH       = 5,
    parameter int unsigned C_TCAM_DATA_WIDTH       = 32,
    parameter int unsigned C_TCAM_MATCH_ADDR_WIDTH = 5,
    parameter int unsigned CAM_LATENCY             = 1,
    parameter int unsigned STARVE_LIMIT            = 16
) (
    input logic                 axis_aclk,
    input logic                 axis_resetn,
    cam_access_arbiter_if.slave bus
`ifdef CAM_ARB_STATS_EN
    ,
    output logic [31:0]         stat_lookups,
    output logic [31:0]         stat_hits,
    output logic [31:0]         stat_writes
`endif
);
    typedef enum logic [1:0] {StIdle, StDrain, StWrIssue, StWrWait} state_e;

    localparam logic [7:0] StarveLim = 8'(STARVE_LIMIT);

    state_e                             state_q, state_d;
    logic [CAM_LATENCY:0]               tag_q;
    logic [C_TCAM_DATA_WIDTH-1:0]       cmp_q;
    logic                               res_valid_q, res_match_q;
    logic [C_TCAM_MATCH_ADDR_WIDTH-1:0] res_addr_q;
    logic                               wr_pend_q, wr_pend_d;
    logic [C_TCAM_ADDR_WIDTH-1:0]       hold_addr_q;
    logic [C_TCAM_DATA_WIDTH-1:0]       hold_data_q;
    logic                               wr_ready_q;
    logic                               wr_done_q, wr_done_d;
    logic [7:0]                         starve_q, starve_d;
    logic                               rst_done_q;
    logic                               starved, lkp_ready, lkp_acc, wr_acc, inflight;

    // rst_done_q keeps lkp_ready low for the first cycle out of reset.
    assign starved   = wr_pend_q & (starve_q == StarveLim);
    assign lkp_ready = rst_done_q & (state_q == StIdle) & ~bus.cam_busy & ~starved;
    assign lkp_acc   = bus.lkp_valid & lkp_ready;
    assign wr_acc    = bus.wr_valid & wr_ready_q;
    assign inflight  = |tag_q;

    always_comb begin
        state_d   = state_q;
        wr_pend_d = wr_pend_q;
        wr_done_d = 1'b0;
        starve_d  = starve_q;
        if (wr_acc) begin
            wr_pend_d = 1'b1;
        end
        if (wr_pend_q && lkp_acc) begin
            starve_d = starve_q + 8'd1;
        end
        unique case (state_q)
            StIdle: begin
                // A write accepted this cycle counts as pending for the drain decision.
                if ((wr_pend_q || wr_acc) && !lkp_acc) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!inflight && !bus.cam_busy) begin
                    state_d  = StWrIssue;
                    starve_d = 8'd0;
                end
            end
            StWrIssue: begin
                state_d = StWrWait;
            end
            StWrWait: begin
                if (!bus.cam_busy) begin
                    state_d   = StIdle;
                    wr_done_d = 1'b1;
                    wr_pend_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            state_q     <= StIdle;
            tag_q       <= '0;
            cmp_q       <= '0;
            res_valid_q <= 1'b0;
            res_match_q <= 1'b0;
            res_addr_q  <= '0;
            wr_pend_q   <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            wr_ready_q  <= 1'b0;
            wr_done_q   <= 1'b0;
            starve_q    <= 8'd0;
            rst_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tag_q       <= {tag_q[CAM_LATENCY-1:0], lkp_acc};
            res_valid_q <= tag_q[CAM_LATENCY];
            wr_pend_q   <= wr_pend_d;
            wr_ready_q  <= ~wr_pend_d;
            wr_done_q   <= wr_done_d;
            starve_q    <= starve_d;
            rst_done_q  <= 1'b1;
            if (lkp_acc) begin
                cmp_q <= bus.lkp_key;
            end
            if (tag_q[CAM_LATENCY]) begin
                res_match_q <= bus.cam_match;
                res_addr_q  <= bus.cam_match_addr;
            end
            if (wr_acc) begin
                hold_addr_q <= bus.wr_addr;
                hold_data_q <= bus.wr_data;
            end
        end
    end

    assign bus.lkp_ready   = lkp_ready;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_match   = res_match_q;
    assign bus.res_addr    = res_addr_q;
    assign bus.wr_ready    = wr_ready_q;
    assign bus.wr_done     = wr_done_q;
    assign bus.cam_we      = (state_q == StWrIssue);
    assign bus.cam_addr_wr = hold_addr_q;
    assign bus.cam_din     = hold_data_q;
    assign bus.cam_cmp_din = cmp_q;

`ifdef CAM_ARB_STATS_EN
    logic [31:0] stat_lookups_q, stat_hits_q, stat_writes_q;

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            stat_lookups_q <= 32'd0;
            stat_hits_q    <= 32'd0;
            stat_writes_q  <= 32'd0;
        end else begin
            if (res_valid_q) begin
                stat_lookups_q <= stat_lookups_q + 32'd1;
            end
            if (res_valid_q && res_match_q) begin
                stat_hits_q <= stat_hits_q + 32'd1;
            end
            if (wr_done_q) begin
                stat_writes_q <= stat_writes_q + 32'd1;
            end
        end
    end

    assign stat_lookups = stat_lookups_q;
    assign stat_hits    = stat_hits_q;
    assign stat_writes  = stat_writes_q;
`endif
endmodule

// File: tb/tb_cam_access_arbiter.sv
// Directed bench for cam_access_arbiter with a behavioural CAM (latency 1, BUSY after writes).
// Stats checks compile in when CAM_ARB_STATS_EN is defined.
module tb_cam_access_arbiter;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 5;
    localparam logic [31:0] KeyHit = 32'h0A0B0C0D;
    localparam logic [31:0] Keys [8] = '{32'h11111111, 32'h22222222, 32'h0A0B0C0D,
        32'h33333333, 32'h0A0B0C0C, 32'h44444444, 32'hDEADBEEF, 32'h0A0B0C0E};

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cam_access_arbiter_if #(
        .C_TCAM_ADDR_WIDTH      (AW),
        .C_TCAM_DATA_WIDTH      (DW),
        .C_TCAM_MATCH_ADDR_WIDTH(MW)
    ) bus ();

`ifdef CAM_ARB_STATS_EN
    logic [31:0] stat_lookups, stat_hits, stat_writes;
`endif

    cam_access_arbiter #(
        .C_TCAM_ADDR_WIDTH      (AW),
        .C_TCAM_DATA_WIDTH      (DW),
        .C_TCAM_MATCH_ADDR_WIDTH(MW),
        .CAM_LATENCY            (1),
        .STARVE_LIMIT           (4)
    ) dut (
        .axis_aclk  (clk),
        .axis_resetn(rstn),
        .bus        (bus)
`ifdef CAM_ARB_STATS_EN
        ,
        .stat_lookups(stat_lookups),
        .stat_hits   (stat_hits),
        .stat_writes (stat_writes)
`endif
    );

    // Behavioural CAM: registered compare, lowest matching index wins, BUSY busy_len cycles.
    logic          model_rst, init_busy;
    int unsigned   busy_len, busy_cnt;
    logic [DW-1:0] ent_data [2**AW];
    logic          ent_vld  [2**AW];
    logic          match_q;
    logic [MW-1:0] maddr_q;

    assign bus.cam_busy       = init_busy | (busy_cnt != 0);
    assign bus.cam_match      = match_q;
    assign bus.cam_match_addr = maddr_q;

    always @(posedge clk) begin : cam_model
        logic          m;
        logic [MW-1:0] a;
        m = 1'b0;
        a = '0;
        for (int i = 2**AW - 1; i >= 0; i--) begin
            if (ent_vld[i] === 1'b1 && ent_data[i] == bus.cam_cmp_din) begin
                m = 1'b1;
                a = MW'(i);
            end
        end
        match_q <= m;
        maddr_q <= a;
        if (model_rst) begin
            for (int i = 0; i < 2**AW; i++) begin
                ent_vld[i]  <= 1'b0;
                ent_data[i] <= '0;
            end
            ent_vld[5]  <= 1'b1;
            ent_data[5] <= KeyHit;
            busy_cnt    <= 0;
        end else if (bus.cam_we) begin
            ent_vld[bus.cam_addr_wr]  <= 1'b1;
            ent_data[bus.cam_addr_wr] <= bus.cam_din;
            busy_cnt                  <= busy_len;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if (bus.lkp_ready !== 1'b0) begin errors++;
            $display("FAIL reset_lkp_ready got %b want 0", bus.lkp_ready); end
        checks++; if (bus.wr_ready !== 1'b0) begin errors++;
            $display("FAIL reset_wr_ready got %b want 0", bus.wr_ready); end
        checks++; if (bus.res_valid !== 1'b0 || bus.res_match !== 1'b0 || bus.res_addr !== '0)
            begin errors++; $display("FAIL reset_res got v=%b m=%b a=%0d want 0", bus.res_valid,
            bus.res_match, bus.res_addr); end
        checks++; if (bus.cam_we !== 1'b0 || bus.wr_done !== 1'b0) begin errors++;
            $display("FAIL reset_we_done got we=%b done=%b want 0", bus.cam_we, bus.wr_done); end
        checks++; if (bus.cam_cmp_din !== '0 || bus.cam_din !== '0 || bus.cam_addr_wr !== '0)
            begin errors++; $display("FAIL reset_cam_bus got cmp=%h din=%h a=%0d want 0",
            bus.cam_cmp_din, bus.cam_din, bus.cam_addr_wr); end
        rstn = 1'b1;
        model_rst = 1'b0;
        step();
        checks++; if (bus.lkp_ready !== 1'b1) begin errors++;
            $display("FAIL post_reset_lkp_ready got %b want 1", bus.lkp_ready); end
        checks++; if (bus.wr_ready !== 1'b1) begin errors++;
            $display("FAIL post_reset_wr_ready got %b want 1", bus.wr_ready); end
    endtask

    task automatic test_back_to_back();
        logic exp_v, exp_m;
        for (int k = 0; k < 12; k++) begin
            bus.lkp_valid = (k < 8);
            bus.lkp_key   = (k < 8) ? Keys[k] : '0;
            #1;
            if (k < 8) begin
                checks++; if (bus.lkp_ready !== 1'b1) begin errors++;
                    $display("FAIL b2b_ready[%0d] got %b want 1", k, bus.lkp_ready); end
            end
            exp_v = (k >= 3 && k < 11);
            checks++; if (bus.res_valid !== exp_v) begin errors++;
                $display("FAIL b2b_res_valid[%0d] got %b want %b", k, bus.res_valid, exp_v); end
            if (exp_v) begin
                exp_m = (Keys[k-3] == KeyHit);
                checks++; if (bus.res_match !== exp_m) begin errors++;
                    $display("FAIL b2b_match[%0d] got %b want %b", k, bus.res_match, exp_m); end
                if (exp_m) begin
                    checks++; if (bus.res_addr !== MW'(5)) begin errors++;
                        $display("FAIL b2b_addr got %0d want 5", bus.res_addr); end
                end
            end
            step();
        end
        bus.lkp_valid = 1'b0;
    endtask

    task automatic test_idle_write();
        int we_k = -1, done_k = -1, we_n = 0, done_n = 0;
        busy_len = 10;
        for (int k = 0; k < 32; k++) begin
            bus.wr_valid = (k == 0);
            bus.wr_addr  = 5'd3;
            bus.wr_data  = 32'h12345678;
            #1;
            if (k == 0) begin
                checks++; if (bus.wr_ready !== 1'b1) begin errors++;
                    $display("FAIL idle_wr_ready got %b want 1", bus.wr_ready); end
            end
            if (bus.cam_we === 1'b1) begin
                we_n++;
                if (we_k < 0) we_k = k;
                checks++; if (bus.cam_addr_wr !== 5'd3 || bus.cam_din !== 32'h12345678) begin
                    errors++; $display("FAIL idle_we_payload got a=%0d d=%h want 3/12345678",
                    bus.cam_addr_wr, bus.cam_din); end
            end
            if (bus.wr_done === 1'b1) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            step();
        end
        bus.wr_valid = 1'b0;
        checks++; if (we_n != 1 || we_k != 2) begin errors++;
            $display("FAIL idle_we got n=%0d at %0d want 1 at 2", we_n, we_k); end
        checks++; if (done_n != 1 || done_k != 14) begin errors++;
            $display("FAIL idle_done got n=%0d at %0d want 1 at 14", done_n, done_k); end
        for (int k = 0; k < 6; k++) begin
            bus.lkp_valid = (k == 0);
            bus.lkp_key   = 32'h12345678;
            #1;
            if (k == 0) begin
                checks++; if (bus.lkp_ready !== 1'b1) begin errors++;
                    $display("FAIL idle_lkp_ready got %b want 1", bus.lkp_ready); end
            end
            if (k == 3) begin
                checks++; if (bus.res_valid !== 1'b1 || bus.res_match !== 1'b1 ||
                    bus.res_addr !== MW'(3)) begin errors++;
                    $display("FAIL idle_readback got v=%b m=%b a=%0d want 1/1/3",
                    bus.res_valid, bus.res_match, bus.res_addr); end
            end
            step();
        end
        bus.lkp_valid = 1'b0;
    endtask

    task automatic test_starvation();
        int blk_k = -1, rdy_k = -1, we_k = -1, done_k = -1, we_n = 0, n_after = 0, last_acc = -1;
        logic acc;
        busy_len = 3;
        for (int k = 0; k < 40; k++) begin
            bus.lkp_valid = (k < 36);
            bus.lkp_key   = 32'h100 + k;
            bus.wr_valid  = (k == 2);
            bus.wr_addr   = 5'd7;
            bus.wr_data   = 32'hCAFEF00D;
            #1;
            if (k == 2) begin
                checks++; if (bus.wr_ready !== 1'b1) begin errors++;
                    $display("FAIL starve_wr_ready got %b want 1", bus.wr_ready); end
            end
            acc = bus.lkp_valid & bus.lkp_ready;
            if (k > 2 && blk_k < 0 && bus.lkp_ready !== 1'b1) blk_k = k;
            if (k > 2 && blk_k < 0 && acc) begin
                n_after++;
                last_acc = k;
            end
            if (blk_k >= 0 && k > blk_k && rdy_k < 0 && bus.lkp_ready === 1'b1) rdy_k = k;
            if (bus.cam_we === 1'b1) begin
                we_n++;
                if (we_k < 0) we_k = k;
                checks++; if (bus.cam_addr_wr !== 5'd7 || bus.cam_din !== 32'hCAFEF00D) begin
                    errors++; $display("FAIL starve_we_payload got a=%0d d=%h want 7/cafef00d",
                    bus.cam_addr_wr, bus.cam_din); end
            end
            if (bus.wr_done === 1'b1 && done_k < 0) done_k = k;
            step();
        end
        bus.lkp_valid = 1'b0;
        bus.wr_valid  = 1'b0;
        checks++; if (n_after != 4 || blk_k != 7) begin errors++;
            $display("FAIL starve_accepts got %0d then block at %0d want 4 then 7", n_after, blk_k);
        end
        checks++; if (we_n != 1 || we_k != last_acc + 4 || we_k != 10) begin errors++;
            $display("FAIL starve_we got n=%0d at %0d want 1 at 10", we_n, we_k); end
        checks++; if (done_k != 15) begin errors++;
            $display("FAIL starve_done got %0d want 15", done_k); end
        checks++; if (rdy_k != done_k) begin errors++;
            $display("FAIL starve_ready_return got %0d want %0d", rdy_k, done_k); end
    endtask

    task automatic test_init_busy();
        int we_k = -1, done_k = -1, acc_k = -1, we_n = 0, viol = 0;
        logic wr_sent = 1'b0;
        init_busy = 1'b1;
        busy_len  = 3;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (k == 20) init_busy = 1'b0;
            bus.lkp_valid = (acc_k < 0);
            bus.lkp_key   = KeyHit;
            bus.wr_valid  = !wr_sent;
            bus.wr_addr   = 5'd9;
            bus.wr_data   = 32'h55AA55AA;
            #1;
            if (k < 20 && (bus.lkp_ready !== 1'b0 || bus.cam_we !== 1'b0)) viol++;
            if (bus.wr_valid && bus.wr_ready === 1'b1) wr_sent = 1'b1;
            if (bus.lkp_valid && bus.lkp_ready === 1'b1 && acc_k < 0) acc_k = k;
            if (bus.cam_we === 1'b1) begin
                we_n++;
                if (we_k < 0) we_k = k;
            end
            if (bus.wr_done === 1'b1 && done_k < 0) done_k = k;
            if (acc_k >= 0 && k == acc_k + 3) begin
                checks++; if (bus.res_valid !== 1'b1 || bus.res_match !== 1'b1 ||
                    bus.res_addr !== MW'(5)) begin errors++;
                    $display("FAIL init_result got v=%b m=%b a=%0d want 1/1/5",
                    bus.res_valid, bus.res_match, bus.res_addr); end
            end
            step();
        end
        bus.lkp_valid = 1'b0;
        bus.wr_valid  = 1'b0;
        checks++; if (viol != 0) begin errors++;
            $display("FAIL init_blocked got %0d busy cycles with ready/we want 0", viol); end
        checks++; if (we_n != 1 || we_k != 21) begin errors++;
            $display("FAIL init_we got n=%0d at %0d want 1 at 21", we_n, we_k); end
        checks++; if (done_k != 26 || acc_k != 26) begin errors++;
            $display("FAIL init_order got done=%0d acc=%0d want 26/26", done_k, acc_k); end
    endtask

    task automatic test_reset_mid();
        int leaks = 0, we_n = 0;
        for (int k = 0; k < 2; k++) begin
            bus.lkp_valid = 1'b1;
            bus.lkp_key   = KeyHit;
            #1;
            checks++; if (bus.lkp_ready !== 1'b1) begin errors++;
                $display("FAIL rmid_lkp_ready[%0d] got %b want 1", k, bus.lkp_ready); end
            step();
        end
        bus.lkp_valid = 1'b0;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        checks++; if (bus.res_valid !== 1'b0 || bus.res_match !== 1'b0 || bus.res_addr !== '0 ||
            bus.cam_cmp_din !== '0) begin errors++;
            $display("FAIL rmid_outputs got v=%b m=%b a=%0d cmp=%h want 0", bus.res_valid,
            bus.res_match, bus.res_addr, bus.cam_cmp_din); end
        checks++; if (bus.lkp_ready !== 1'b0 || bus.wr_ready !== 1'b0) begin errors++;
            $display("FAIL rmid_ready got l=%b w=%b want 0", bus.lkp_ready, bus.wr_ready); end
        for (int k = 0; k < 8; k++) begin
            if (bus.res_valid !== 1'b0) leaks++;
            step();
        end
        checks++; if (leaks != 0) begin errors++;
            $display("FAIL rmid_res_leak got %0d pulses want 0", leaks); end
        busy_len = 10;
        for (int k = 0; k < 5; k++) begin
            bus.wr_valid = (k == 0);
            bus.wr_addr  = 5'd2;
            bus.wr_data  = 32'h0BADCAFE;
            #1;
            if (bus.cam_we === 1'b1) we_n++;
            step();
        end
        bus.wr_valid = 1'b0;
        checks++; if (we_n != 1) begin errors++;
            $display("FAIL rmid_we_before got %0d want 1", we_n); end
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        checks++; if (bus.wr_done !== 1'b0 || bus.cam_we !== 1'b0 || bus.wr_ready !== 1'b0 ||
            bus.cam_din !== '0) begin errors++;
            $display("FAIL rmid_wr_outputs got done=%b we=%b rdy=%b din=%h want 0", bus.wr_done,
            bus.cam_we, bus.wr_ready, bus.cam_din); end
        leaks = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.wr_done !== 1'b0 || bus.cam_we !== 1'b0) leaks++;
            step();
        end
        checks++; if (leaks != 0) begin errors++;
            $display("FAIL rmid_wr_leak got %0d done/we cycles want 0", leaks); end
    endtask

`ifdef CAM_ARB_STATS_EN
    task automatic test_stats();
        logic [31:0] skeys [5];
        skeys = '{KeyHit, 32'h1, 32'h12345678, 32'h2, 32'h3};
        busy_len = 3;
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        checks++; if (stat_lookups !== 0 || stat_hits !== 0 || stat_writes !== 0) begin errors++;
            $display("FAIL stats_reset got %0d/%0d/%0d want 0/0/0", stat_lookups, stat_hits,
            stat_writes); end
        step();
        for (int k = 0; k < 40; k++) begin
            bus.lkp_valid = (k < 5);
            bus.lkp_key   = (k < 5) ? skeys[k] : '0;
            bus.wr_valid  = (k == 10);
            bus.wr_addr   = 5'd10;
            bus.wr_data   = 32'h77777777;
            step();
        end
        bus.lkp_valid = 1'b0;
        bus.wr_valid  = 1'b0;
        checks++; if (stat_lookups !== 5 || stat_hits !== 2 || stat_writes !== 1) begin errors++;
            $display("FAIL stats_counts got %0d/%0d/%0d want 5/2/1", stat_lookups, stat_hits,
            stat_writes); end
    endtask
`endif

    initial begin
        bus.lkp_valid = 1'b0;
        bus.lkp_key   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        init_busy     = 1'b0;
        model_rst     = 1'b1;
        busy_len      = 10;
        rstn          = 1'b0;
        repeat (3) step();
        test_reset();
        test_back_to_back();
        test_idle_write();
        test_starvation();
        test_init_busy();
        test_reset_mid();
`ifdef CAM_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
